// File: rtl/ram_access_arbiter_if.sv
// Bundle between the two word-level requesters, the arbiter and the RAM.
// master = requester/RAM side, slave = ram_access_arbiter.
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              timeout;
    logic              busy;
    logic [DATA_W+1:0] ram_din;
    logic              ram_rx_valid;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_tx_valid;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ram_dout, ram_tx_valid,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, timeout, busy,
        input  ram_din, ram_rx_valid
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ram_dout, ram_tx_valid,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, timeout, busy,
        output ram_din, ram_rx_valid
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter that turns requester words into the RAM's
// two-word command sequences and returns read bytes to their owner.
module ram_access_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    ram_access_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_WAIT
    } state_e;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    state_e            state_q;
    logic              last_q;
    logic              owner_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W+1:0] din_q;
    logic              rx_q;
    logic              rv0_q;
    logic              rv1_q;
    logic              to_q;
    logic              busy_q;

    logic              any_d;
    logic              win_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grant is decoded live from the requests; reset masks it.
    always_comb begin
        any_d     = (state_q == IDLE) && !rst && (bus.req0 || bus.req1);
        win_d     = bus.req1 && (!bus.req0 || !last_q);
        sel_we    = win_d ? bus.we1 : bus.we0;
        sel_addr  = win_d ? bus.addr1 : bus.addr0;
        sel_wdata = win_d ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            rx_q    <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_q  <= 1'b0;
            din_q <= '0;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            to_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_d) begin
                        owner_q <= win_d;
                        last_q  <= win_d;
                        wdata_q <= sel_wdata;
                        rx_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        din_q   <= {sel_we ? OP_WA : OP_RA, DATA_W'(sel_addr)};
                        state_q <= sel_we ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    rx_q    <= 1'b1;
                    din_q   <= {OP_WD, wdata_q};
                    state_q <= WR_DATA;
                end
                WR_DATA: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                RD_ADDR: begin
                    rx_q    <= 1'b1;
                    din_q   <= {OP_RD, {DATA_W{1'b0}}};
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.ram_tx_valid) begin
                        rdata_q <= bus.ram_dout;
                        rv0_q   <= !owner_q;
                        rv1_q   <= owner_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q >= CNT_LAST) begin
                        to_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt0         = any_d && !win_d;
    assign bus.gnt1         = any_d && win_d;
    assign bus.rvalid0      = rv0_q;
    assign bus.rvalid1      = rv1_q;
    assign bus.rdata        = rdata_q;
    assign bus.timeout      = to_q;
    assign bus.busy         = busy_q;
    assign bus.ram_din      = din_q;
    assign bus.ram_rx_valid = rx_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench: a cycle-level transaction model predicts grants,
// RAM commands and responses; monitors compare as the DUT presents them.
`timescale 1ns/1ps
module tb_ram_access_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         dly;
    } txn_t;
    typedef struct {
        int         cyc;
        logic [9:0] w;
    } cmd_t;
    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [7:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    txn_t       qin[2][$];
    txn_t       cur[2];
    bit         pend[2];
    bit         drop[2];
    cmd_t       exp_cmd[$];
    rsp_t       exp_rsp[$];
    logic [7:0] ref_mem[256];
    logic [7:0] ram_mem[256];
    int         cyc = 0;
    int         free_cyc = 0;
    int         gcyc = -1;
    int         ram_delay = -1;
    int         total = 0;
    int         bad = 0;
    bit         last_w = 1'b1;
    bit         chk_en = 1'b0;
    bit         stray_en = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    task automatic note_fail(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want nothing at cycle %0d", nm, act, cyc);
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we    = 1'($urandom_range(1, 0));
        t.addr  = 8'($urandom_range(15, 0));
        t.wdata = 8'($urandom);
        case ($urandom_range(9, 0))
            0:       t.dly = -1;
            1:       t.dly = TO - 1;
            default: t.dly = int'($urandom_range(3, 0));
        endcase
        return t;
    endfunction

    task automatic drive(input int i, input bit r, input txn_t t);
        if (i == 0) begin
            bus.req0 = r; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
        end else begin
            bus.req1 = r; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
        end
    endtask

    // Reference: one transaction at a time, fixed command/response latencies.
    task automatic accept(input int w);
        txn_t t = cur[w];
        last_w  = w[0];
        pend[w] = 1'b0;
        drop[w] = 1'b1;
        gcyc    = cyc;
        if (t.we) begin
            exp_cmd.push_back('{cyc + 1, {2'b00, t.addr}});
            exp_cmd.push_back('{cyc + 2, {2'b01, t.wdata}});
            ref_mem[t.addr] = t.wdata;
            free_cyc = cyc + 3;
        end else begin
            exp_cmd.push_back('{cyc + 1, {2'b10, t.addr}});
            exp_cmd.push_back('{cyc + 2, 10'h300});
            ram_delay = t.dly;
            if (t.dly >= 0) begin
                exp_rsp.push_back('{cyc + 4 + t.dly, (w == 1) ? 3'b010 : 3'b001, ref_mem[t.addr]});
                free_cyc = cyc + 4 + t.dly;
            end else begin
                exp_rsp.push_back('{cyc + 3 + TO, 3'b100, 8'h00});
                free_cyc = cyc + 3 + TO;
            end
        end
    endtask

    task automatic check_grant();
        int w = -1;
        int ge;
        if (cyc >= free_cyc) begin
            if (pend[0] && pend[1]) w = last_w ? 0 : 1;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
        end
        ge = (w < 0) ? 0 : ((w == 0) ? 1 : 2);
        chk("gnt", {30'b0, bus.gnt1, bus.gnt0}, ge);
        if (w >= 0) accept(w);
    endtask

    task automatic tick(input bit eager);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
                drop[i] = 1'b0;
                drive(i, 1'b0, rnd_txn());
            end
            if (!pend[i] && qin[i].size() > 0 && (eager || $urandom_range(1, 0) == 1)) begin
                cur[i]  = qin[i].pop_front();
                pend[i] = 1'b1;
                drive(i, 1'b1, cur[i]);
            end
        end
        #1;
        check_grant();
    endtask

    task automatic drain(input bit eager);
        int g = 0;
        while ((qin[0].size() > 0 || qin[1].size() > 0 || pend[0] || pend[1]) && g < 3000) begin
            tick(eager);
            g++;
        end
        if (g >= 3000) note_fail("drain_budget", g);
    endtask

    task automatic settle();
        int g = 0;
        while (cyc < free_cyc + 2 && g < 100) begin
            tick(1'b1);
            g++;
        end
        if (g >= 100) note_fail("settle_budget", g);
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_gnt"}, {30'b0, bus.gnt1, bus.gnt0}, 0);
        chk({nm, "_rsp"}, {29'b0, bus.timeout, bus.rvalid1, bus.rvalid0}, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_rx"}, bus.ram_rx_valid, 0);
        chk({nm, "_din"}, bus.ram_din, 0);
        chk({nm, "_rdata"}, bus.rdata, 0);
    endtask

    // RAM model: stores writes, answers reads after ram_delay, else stray tx.
    logic [7:0] rm_waddr, rm_raddr;
    bit         rm_busy = 1'b0;
    bit         rm_sched = 1'b0;
    int         rm_cyc, rm_cmd_cyc;
    always @(negedge clk) begin
        if (rst) begin
            rm_busy = 1'b0;
            rm_sched = 1'b0;
            bus.ram_tx_valid = 1'b0;
        end else begin
            bus.ram_tx_valid = 1'b0;
            bus.ram_dout = 8'($urandom);
            if (rm_sched && cyc == rm_cyc) begin
                bus.ram_tx_valid = 1'b1;
                bus.ram_dout = ram_mem[rm_raddr];
                rm_sched = 1'b0;
                rm_busy = 1'b0;
            end else if (stray_en && !rm_busy && $urandom_range(3, 0) == 0) begin
                bus.ram_tx_valid = 1'b1;
            end
            if (rm_busy && cyc > rm_cmd_cyc + TO + 1) rm_busy = 1'b0;
            if (bus.ram_rx_valid) begin
                case (bus.ram_din[9:8])
                    2'b00: rm_waddr = bus.ram_din[7:0];
                    2'b01: ram_mem[rm_waddr] = bus.ram_din[7:0];
                    2'b10: rm_raddr = bus.ram_din[7:0];
                    default: begin
                        rm_busy = 1'b1;
                        rm_cmd_cyc = cyc;
                        if (ram_delay >= 0) begin
                            rm_sched = 1'b1;
                            rm_cyc = cyc + 1 + ram_delay;
                        end
                    end
                endcase
            end
        end
    end

    cmd_t       m_c;
    rsp_t       m_r;
    logic [2:0] m_p;
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            if (bus.ram_rx_valid) begin
                if (exp_cmd.size() == 0) note_fail("cmd_extra", bus.ram_din);
                else begin
                    m_c = exp_cmd.pop_front();
                    chk("cmd_word", bus.ram_din, m_c.w);
                    chk("cmd_cycle", cyc, m_c.cyc);
                end
            end else chk("din_idle", bus.ram_din, 0);
            m_p = {bus.timeout, bus.rvalid1, bus.rvalid0};
            if (m_p != 3'b000) begin
                if (exp_rsp.size() == 0) note_fail("rsp_extra", m_p);
                else begin
                    m_r = exp_rsp.pop_front();
                    chk("rsp_kind", m_p, m_r.p);
                    chk("rsp_cycle", cyc, m_r.cyc);
                    if (m_r.p != 3'b100) begin
                        chk("rdata", bus.rdata, m_r.d);
                        m_rdata = m_r.d;
                    end else chk("rdata_hold", bus.rdata, m_rdata);
                end
            end else chk("rdata_hold", bus.rdata, m_rdata);
            chk("busy", bus.busy, (cyc > gcyc && cyc < free_cyc));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.ram_tx_valid = 1'b0; bus.ram_dout = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            ram_mem[i] = ref_mem[i];
        end
        repeat (2) @(negedge clk);
        #1;
        chk_rst("rst_init");
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        qin[0].push_back('{1'b1, 8'h3C, 8'hA5, 0});
        drain(1'b1);
        settle();
        qin[1].push_back('{1'b0, 8'h3C, 8'h00, 0});
        drain(1'b1);
        settle();

        for (int k = 0; k < 6; k++) begin
            qin[0].push_back(rnd_txn());
            qin[1].push_back(rnd_txn());
        end
        drain(1'b1);
        settle();

        qin[0].push_back('{1'b0, 8'h05, 8'h00, -1});
        qin[1].push_back('{1'b1, 8'h06, 8'h5A, 0});
        drain(1'b1);
        settle();
        qin[1].push_back('{1'b0, 8'h3C, 8'h00, TO - 1});
        drain(1'b1);
        settle();

        stray_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            t = rnd_txn();
            qin[$urandom_range(1, 0)].push_back(t);
        end
        drain(1'b0);
        settle();
        stray_en = 1'b0;

        qin[1].push_back('{1'b0, 8'h10, 8'h00, -1});
        drain(1'b1);
        repeat (4) tick(1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #1;
        chk_rst("rst_mid");
        repeat (3) @(negedge clk);
        #1;
        chk_rst("rst_hold");
        exp_cmd.delete();
        exp_rsp.delete();
        last_w = 1'b1;
        free_cyc = 0;
        gcyc = -1;
        m_rdata = 8'h00;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drop[0] = 1'b0; drop[1] = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) tick(1'b1);
        qin[0].push_back('{1'b1, 8'h21, 8'h11, 0});
        qin[1].push_back('{1'b1, 8'h22, 8'h22, 0});
        drain(1'b1);
        settle();

        chk("cmd_q_empty", exp_cmd.size(), 0);
        chk("rsp_q_empty", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
